// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data SRAM responder.
//   SZ_B/SZ_H/SZ_W : encodings of the master's size field (informational only)
//   req_entry_t    : one accepted request as held in the request queue
//   IDX_W          : stored word-index width; wide enough for any ADDR_W the
//                    top supports, the top zero-extends its narrower index
package data_sram_responder_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int IDX_W = 30;
  localparam int CD_W  = 3;

  typedef struct packed {
    logic             wr;
    logic [IDX_W-1:0] index;
    logic [3:0]       wstrb;
    logic [31:0]      wdata;
    logic [CD_W-1:0]  countdown;
  } req_entry_t;

  // Byte-lane merge of a write into an existing word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_req_fifo.sv
// req_fifo: in-order queue of accepted requests, each carrying its own
// latency countdown.
//   clk, reset        : clock, synchronous active-high reset
//   push, push_entry  : enqueue (ignored when full)
//   pop               : dequeue the head (ignored when empty)
//   tick              : decrement every nonzero countdown this cycle
//   full, empty       : occupancy flags from the registered count
//   head              : entry at the read pointer
//   empty_next,
//   head_next         : what empty/head will be next cycle, so the parent can
//                       register its response one cycle ahead
module req_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  req_entry_t push_entry,
  input  logic       pop,
  input  logic       tick,
  output logic       full,
  output logic       empty,
  output req_entry_t head,
  output logic       empty_next,
  output req_entry_t head_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

  req_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  function automatic req_entry_t aged(input req_entry_t e, input logic t);
    req_entry_t r;
    r = e;
    if (t && (r.countdown != '0)) r.countdown = r.countdown - 1'b1;
    return r;
  endfunction

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign head        = entries[rd_ptr];
  assign rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign empty_next  = (count_next == '0);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (!do_push && do_pop) count_next = count - 1'b1;
  end

  // The slot being written can only become the next head when nothing else
  // remains queued ahead of it; otherwise the next head is an existing entry
  // one tick older.
  always_comb begin
    head_next = aged(entries[rd_ptr_next], tick);
    if (do_push && (wr_ptr == rd_ptr_next)) head_next = push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].countdown <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= aged(entries[i], tick);
      if (do_push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: word-organised SRAM behind a req/addr_ok, data_ok
// handshake with a fixed response latency and up to DEPTH requests in flight.
//   clk, reset : clock, synchronous active-high reset
//   req, wr    : request strobe and direction (1 = write)
//   size       : access size, informational; wstrb selects the lanes
//   wstrb      : write byte enables
//   addr       : byte address; only the word index addr[ADDR_W+1:2] is used
//   wdata      : lane-aligned write data
//   addr_ok    : request accepted this cycle
//   data_ok    : one in-order response completes this cycle
//   rdata      : read word during a read response, otherwise 0
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int WORDS = 1 << ADDR_W;

  logic [31:0]       mem [WORDS];
  req_entry_t        push_entry;
  req_entry_t        head;
  req_entry_t        head_next;
  logic              full;
  logic              empty;
  logic              empty_next;
  logic              data_ok_q;
  logic [31:0]       rdata_q;
  logic              resp_next;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] nxt_idx;
  logic [31:0]       wr_word;
  logic [31:0]       nxt_word;
  logic              unused_bits;

  assign addr_ok = req && !full && !reset;
  assign data_ok = data_ok_q && !reset;
  assign rdata   = reset ? '0 : rdata_q;

  always_comb begin
    push_entry           = '0;
    push_entry.wr        = wr;
    push_entry.index     = IDX_W'(addr[ADDR_W+1:2]);
    push_entry.wstrb     = wstrb;
    push_entry.wdata     = wdata;
    push_entry.countdown = CD_W'(LATENCY);
  end

  req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (addr_ok),
    .push_entry (push_entry),
    .pop        (data_ok),
    .tick       (1'b1),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .empty_next (empty_next),
    .head_next  (head_next)
  );

  // A write retires in its data_ok cycle; gating by data_ok keeps writes of
  // requests discarded by reset out of the array.
  assign mem_we  = data_ok && head.wr;
  assign wr_idx  = head.index[ADDR_W-1:0];
  assign wr_word = merge_lanes(mem[wr_idx], head.wdata, head.wstrb);

  // The next response is registered now, so a read retiring right after a
  // write to the same word must see the word being written this cycle.
  assign nxt_idx   = head_next.index[ADDR_W-1:0];
  assign nxt_word  = (mem_we && (nxt_idx == wr_idx)) ? wr_word : mem[nxt_idx];
  assign resp_next = !empty_next && (head_next.countdown == '0);

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= resp_next;
      rdata_q   <= (resp_next && !head_next.wr) ? nxt_word : '0;
    end
  end

  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0], empty,
                         head.index[IDX_W-1:ADDR_W], head.countdown,
                         head_next.index[IDX_W-1:ADDR_W], head_next.wstrb,
                         head_next.wdata};

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int N   = 3;
  localparam int DEP = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N-1:0]       wr;
  logic [N-1:0]       addr_ok;
  logic [N-1:0]       data_ok;
  logic [N-1:0][1:0]  size;
  logic [N-1:0][3:0]  wstrb;
  logic [N-1:0][31:0] addr;
  logic [N-1:0][31:0] wdata;
  logic [N-1:0][31:0] rdata;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEP), .LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .wstrb(wstrb[0]), .addr(addr[0]), .wdata(wdata[0]),
    .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEP), .LATENCY(7)) dut_l7 (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .wstrb(wstrb[1]), .addr(addr[1]), .wdata(wdata[1]),
    .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEP), .LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .size(size[2]),
    .wstrb(wstrb[2]), .addr(addr[2]), .wdata(wdata[2]),
    .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

  typedef struct {
    int          inst;
    logic        wr;
    int          idx;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [int];
  int          last_due [N];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    case (i)
      0:       return 2;
      1:       return 7;
      default: return 0;
    endcase
  endfunction

  function automatic string tg(input string s, input int i);
    return $sformatf("%s_%0d", s, i);
  endfunction

  function automatic int first_of(input int i);
    foreach (sb[k]) if (sb[k].inst == i) return k;
    return -1;
  endfunction

  function automatic int count_of(input int i);
    int n = 0;
    foreach (sb[k]) if (sb[k].inst == i) n++;
    return n;
  endfunction

  function automatic int key(input int i, input int idx);
    return i * 4096 + idx;
  endfunction

  function automatic logic [31:0] mread(input int i, input int idx);
    if (mm.exists(key(i, idx))) return mm[key(i, idx)];
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, expv, cyc);
    end
  endtask

  // Per-instance scoreboard step, evaluated mid-cycle with stable inputs.
  // Queue size before this cycle's pop/push equals the registered count.
  task automatic observe(input int i);
    int          k;
    int          n;
    exp_t        e;
    logic        due_now;
    logic [31:0] er;
    logic [31:0] w;
    n = count_of(i);
    k = first_of(i);
    if (reset) begin
      chk(tg("addr_ok_rst", i), 32'(addr_ok[i]), 32'h0);
      chk(tg("data_ok_rst", i), 32'(data_ok[i]), 32'h0);
      chk(tg("rdata_rst", i), rdata[i], 32'h0);
      for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].inst == i) sb.delete(j);
      last_due[i] = 0;
      return;
    end
    chk(tg("addr_ok", i), 32'(addr_ok[i]), 32'(req[i] && (n < DEP)));
    due_now = (k >= 0) && (sb[k].due == cyc);
    chk(tg("data_ok", i), 32'(data_ok[i]), 32'(due_now));
    if (data_ok[i] && (k >= 0)) begin
      e = sb[k];
      sb.delete(k);
      er = e.wr ? 32'h0 : mread(i, e.idx);
      chk(tg(e.wr ? "wr_rdata" : "rd_data", i), rdata[i], er);
      if (e.wr) begin
        w = mread(i, e.idx);
        for (int b = 0; b < 4; b++) if (e.strb[b]) w[8*b +: 8] = e.wdata[8*b +: 8];
        mm[key(i, e.idx)] = w;
      end
    end else begin
      chk(tg("rdata_idle", i), rdata[i], 32'h0);
    end
    if (req[i] && (n < DEP)) begin
      e.inst  = i;
      e.wr    = wr[i];
      e.idx   = int'(addr[i][11:2]);
      e.strb  = wstrb[i];
      e.wdata = wdata[i];
      e.due   = (cyc + 1 + lat(i) > last_due[i] + 1) ? cyc + 1 + lat(i) : last_due[i] + 1;
      last_due[i] = e.due;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) observe(i);
  end

  // Hold a request until it is accepted, then release it right after the edge.
  task automatic xfer(input int i, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    int t = 0;
    req[i]   = 1'b1;
    wr[i]    = w;
    addr[i]  = a;
    wstrb[i] = s;
    wdata[i] = d;
    size[i]  = SZ_W;
    @(negedge clk);
    while (!addr_ok[i] && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    chk(tg("accept", i), 32'(addr_ok[i]), 32'h1);
    @(posedge clk);
    #1;
    req[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    reset = 1'b1;
    req   = '0;
    wr    = '0;
    size  = '0;
    wstrb = '0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // full write then read-back, LATENCY 2
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hAABBCCDD);
    idle(5);
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
    idle(5);

    // partial write followed back-to-back by a read of the same word
    xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    idle(4);
    xfer(0, 1'b1, 32'h20, 4'h2, 32'h0000EE00);
    xfer(0, 1'b0, 32'h20, 4'h0, 32'h0);
    idle(5);

    // zero strobe, single high lane via unaligned addr, upper addr bits ignored
    xfer(0, 1'b1, 32'h24, 4'hF, 32'h55667788);
    xfer(0, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF);
    xfer(0, 1'b1, 32'h27, 4'h8, 32'h99000000);
    xfer(0, 1'b0, 32'h24, 4'h0, 32'h0);
    xfer(0, 1'b1, 32'hFFFFF013, 4'hF, 32'h12345678);
    xfer(0, 1'b0, 32'h10, 4'h0, 32'h0);
    idle(5);

    // pipelined burst of writes then reads
    for (int k = 0; k < 8; k++) xfer(0, 1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'h10203040 + 32'(k) * 32'h01010101);
    for (int k = 0; k < 8; k++) xfer(0, 1'b0, 32'h100 + 32'(4 * k), 4'h0, 32'h0);
    idle(6);

    // queue fills with LATENCY 7; addr_ok stays low through the first dequeue
    for (int k = 0; k < 6; k++) xfer(1, 1'b1, 32'h40 + 32'(4 * k), 4'hF, 32'hA0000000 + 32'(k));
    idle(2);
    for (int k = 0; k < 6; k++) xfer(1, 1'b0, 32'h40 + 32'(4 * k), 4'h0, 32'h0);
    idle(20);

    // LATENCY 0: consecutive responses, and write-then-read of one word
    xfer(2, 1'b1, 32'h0, 4'hF, 32'h01234567);
    xfer(2, 1'b1, 32'h4, 4'hF, 32'h89ABCDEF);
    xfer(2, 1'b1, 32'h8, 4'hF, 32'hFEDCBA98);
    idle(3);
    xfer(2, 1'b0, 32'h0, 4'h0, 32'h0);
    xfer(2, 1'b0, 32'h4, 4'h0, 32'h0);
    xfer(2, 1'b0, 32'h8, 4'h0, 32'h0);
    xfer(2, 1'b1, 32'hC, 4'hF, 32'h5A5A5A5A);
    xfer(2, 1'b0, 32'hC, 4'h0, 32'h0);
    idle(4);

    // reset with three writes outstanding discards them
    xfer(0, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    xfer(0, 1'b1, 32'h34, 4'hF, 32'h0BADC0DE);
    xfer(0, 1'b1, 32'h38, 4'hF, 32'h600DCAFE);
    idle(5);
    xfer(0, 1'b1, 32'h30, 4'hF, 32'h0);
    xfer(0, 1'b1, 32'h34, 4'hF, 32'h0);
    xfer(0, 1'b1, 32'h38, 4'hF, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    xfer(0, 1'b0, 32'h30, 4'h0, 32'h0);
    xfer(0, 1'b0, 32'h34, 4'h0, 32'h0);
    xfer(0, 1'b0, 32'h38, 4'h0, 32'h0);
    idle(5);

    t = 0;
    while ((sb.size() != 0) && (t < 200)) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the number of word-index bits (memory holds 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter DEPTH, default 4, giving the maximum number of outstanding accepted requests (power of 2, at least 2).
REQ-003 SHALL have parameter LATENCY, default 2, giving the extra wait cycles before a response (0..7).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req  input  1  master requests a transaction this cycle.
REQ-007 wr  input  1  1 = write, 0 = read.
REQ-008 size  input  2  access size: 0 = byte, 1 = half, 2 = word. Informational only; wstrb is authoritative.
REQ-009 wstrb  input  4  byte enables for writes; ignored for reads.
REQ-010 addr  input  32  byte address.
REQ-011 wdata  input  32  write data, already lane-aligned by the master.
REQ-012 addr_ok  output  1  the request is accepted this cycle.
REQ-013 data_ok  output  1  one response completes this cycle (read or write).
REQ-014 rdata  output  32  full read word; valid only while data_ok is high for a read.

Function
REQ-015 addr_ok SHALL equal req AND NOT full. It is combinational and depends only on the queue count registered at the start of the cycle.
REQ-016 There is no enqueue bypass when full: a dequeue in the same cycle does not raise addr_ok.
REQ-017 A handshake is req && addr_ok. On a handshake the SHALL enqueue {wr, word index addr[ADDR_W+1:2], wstrb, wdata, countdown = LATENCY}. addr bits above ADDR_W+1 and addr[1:0] are ignored.
REQ-018 Every queued entry's countdown SHALL decrement by 1 each cycle while it is nonzero, starting the cycle after enqueue.
REQ-019 data_ok SHALL be a registered output, high for exactly one cycle, when the head entry's countdown is 0. The head entry is dequeued in that same cycle.
REQ-020 The earliest data_ok for a request accepted in cycle T is cycle T+1+LATENCY. Responses are strictly in order, with at most one per cycle, and back-to-back responses are allowed.
REQ-021 The master never back-pressures data_ok; the responder has no stall input.
REQ-022 Read response: rdata SHALL equal mem[index] as of the data_ok cycle. That value includes all earlier-ordered writes, so read-after-write returns the new data.
REQ-023 Write response: in the data_ok cycle, each byte lane i with wstrb[i]=1 SHALL be updated with wdata[8i+7:8i]. Other lanes are unchanged. A write with wstrb=0 still responds.
REQ-024 rdata SHALL be 0 whenever data_ok is low or the response is a write.
REQ-025 Simultaneous enqueue and dequeue SHALL leave the count unchanged. Read and write pointers wrap modulo DEPTH.
REQ-026 full = (count == DEPTH); empty = (count == 0). When empty, data_ok is 0.

Reset
REQ-027 While reset is high: count, pointers and countdowns SHALL clear; data_ok = 0; rdata = 0; addr_ok = 0.
REQ-028 Reset mid-operation SHALL discard all outstanding requests without responding to them and without applying their writes.
REQ-029 Memory contents SHALL be unaffected by reset. Simulation initialisation to zero is permitted.

Structure
REQ-030 A shared package SHALL hold the size encoding constants (SZ_B = 0, SZ_H = 1, SZ_W = 2) and the request-entry struct type {wr, index, wstrb, wdata, countdown}.
REQ-031 The request queue SHALL be a sub-module named req_fifo, with parameter DEPTH and the ports push, pop, full, empty, head and per-entry countdown tick. The top level holds the memory array and the response register.

Verification
REQ-032 LATENCY=2; write addr 0x10, wdata 0xAABBCCDD, wstrb 0xF, accepted cycle T -> data_ok at T+3 with rdata=0. A later read of 0x10 returns 0xAABBCCDD.
REQ-033 Word 0x20 preset to 0x11223344; write wstrb 0x2, wdata 0x0000EE00, then read 0x20 back-to-back -> read data_ok returns 0x1122EE44 one cycle after the write's data_ok.
REQ-034 DEPTH=4, LATENCY=7; req held high -> exactly 4 handshakes, then addr_ok=0 until the first data_ok. During the dequeue cycle addr_ok stays 0; it rises the following cycle.
REQ-035 LATENCY=0; reads of 0x0, 0x4, 0x8 issued on consecutive cycles -> data_ok high three consecutive cycles, data in order.
REQ-036 Three writes outstanding, reset asserted for 1 cycle -> no data_ok follows, memory unchanged, addr_ok accepts new requests the cycle after reset deasserts.
